fetch_queue: RTL
================

// Module: fetch_queue
//
// PURPOSE
//   Parametrised pipelined fetch unit that replaces the single-cycle PC-increment fetch stage.
//   - Issues one instruction-memory read per cycle from a registered (1-cycle latency) imem.
//   - Buffers returned instructions in a DEPTH-entry FIFO and hands {pc, insn} to decode over valid/ready.
//   - Accepts redirects from execute (branch/jump resolved): flushes the FIFO and cancels the in-flight read.
//   - Sits between the imem port and the decode stage.
//
// PARAMETERS
//   AWIDTH    32            address / PC width
//   DWIDTH    32            instruction width
//   BASEADDR  32'h01000000  PC loaded at reset
//   DEPTH     4             FIFO entries; power of two, >= 2
//
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       reset, asynchronous, active-low
//   redirect_i     in   1       execute redirect strobe, one cycle
//   redirect_pc_i  in   AWIDTH  redirect target
//   imem_req_o     out  1       read request this cycle
//   imem_addr_o    out  AWIDTH  read address (word aligned)
//   imem_rdata_i   in   DWIDTH  read data; valid the cycle after imem_req_o
//   valid_o        out  1       FIFO head valid
//   ready_i        in   1       decode accepts head
//   pc_o           out  AWIDTH  head PC
//   insn_o         out  DWIDTH  head instruction
//   pred_taken_o   out  1       head was predicted taken (0 unless FETCH_STATIC_PRED_EN)
//   count_o        out  $clog2(DEPTH)+1  FIFO occupancy
//
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - fetch PC = BASEADDR; FIFO empty; in-flight flag = 0; FSM = S_BOOT.
//     - Outputs: valid_o 0, pc_o 0, insn_o 0, pred_taken_o 0, count_o 0, imem_req_o 0, imem_addr_o BASEADDR.
//   FSM:
//     - S_BOOT -> S_RUN after one cycle; no request is issued in S_BOOT.
//     - S_RUN -> S_RUN normally; S_RUN -> S_BUBBLE on a prediction redirect (macro only).
//     - S_BUBBLE -> S_RUN after one cycle with no request.
//     - redirect_i in any state -> S_RUN.
//   Issue:
//     - imem_req_o = (state == S_RUN) && (count + inflight - pop < DEPTH), with pop = valid_o & ready_i.
//     - On issue: inflight <= 1; fetch PC += 4, wrapping modulo 2^AWIDTH.
//   Response:
//     - If inflight was set and the read was not cancelled, {pc, imem_rdata_i} is pushed the cycle after issue.
//     - Throughput is 1 insn/cycle with DEPTH >= 2 and ready_i held high.
//   Handshake:
//     - Head transfers when valid_o & ready_i.
//     - pc_o, insn_o and pred_taken_o hold stable while valid_o=1 and ready_i=0.
//     - pc_o, insn_o and pred_taken_o are driven to 0 when the FIFO is empty.
//   Full/empty:
//     - Simultaneous push and pop when full is legal; occupancy is unchanged.
//     - Pop from empty is ignored.
//     - The issue rule means push never overflows.
//   Redirect (redirect_i=1 at edge t):
//     - FIFO cleared and count 0 at t+1.
//     - The response of any read issued at t-1 or t is discarded.
//     - Fetch PC = {redirect_pc_i[AWIDTH-1:2], 2'b00}; the low bits are silently cleared.
//     - First request to the new target is issued at t+1.
//     - A same-cycle pop is performed but the popped entry is lost by the flush; decode must treat it as squashed.
//     - Redirect beats a prediction redirect in the same cycle.
//   Reset mid-operation: every state returns immediately to its reset values; late imem data is ignored.
//
// CONFIGURATION
//   FETCH_STATIC_PRED_EN defined:
//     - Each pushed insn is predecoded.
//     - Taken if JAL (opcode 7'b1101111), or B-type (7'b1100011) with imm[12]=1 (backward branch).
//     - The entry is pushed with pred_taken=1.
//     - Fetch PC = entry pc + sign-extended J/B immediate.
//     - The read issued in the same cycle (sequential PC) is cancelled; FSM enters S_BUBBLE.
//   FETCH_STATIC_PRED_EN undefined:
//     - No predecode; pred_taken_o tied 0; S_BUBBLE is unreachable.
//
// STRUCTURE
//   Package fetch_pkg:
//     - fetch_state_e {S_BOOT, S_RUN, S_BUBBLE}
//     - fetch_entry_t {pc, insn, pred_taken}
//     - OPC_JAL and OPC_BRANCH constants; NOP_INSN = 32'h00000013
//   Sub-module fetch_fifo (DEPTH, entry type): push, pop, flush, count; head registered from storage.
//
// TESTING
//   1. Reset, then release with ready_i=1:
//        imem_addr_o sequence 0x01000000, 0x01000004, ...;
//        valid_o first high 2 cycles after the first req; one insn per cycle thereafter.
//   2. ready_i=0 for 10 cycles:
//        count_o saturates at DEPTH (4); imem_req_o drops; pc_o and insn_o stable;
//        resuming ready_i gives in-order PCs with no gaps or duplicates.
//   3. redirect_i with redirect_pc_i=0x01000103 mid-stream:
//        next imem_addr_o = 0x01000100; stale response dropped; first valid pc_o = 0x01000100.
//   4. redirect_i while full and ready_i=1:
//        count_o=0 on the next cycle; no pre-redirect PC ever appears on pc_o afterwards.
//   5. Fetch PC starting at 0xFFFFFFFC (via redirect): next imem_addr_o = 0x00000000.
//   6. FETCH_STATIC_PRED_EN, insn 0xFE000EE3 (beq, imm=-4) at 0x01000008:
//        pred_taken_o=1; next issued addr 0x01000004; the sequential 0x0100000C is never delivered.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the pipelined fetch queue: FSM states, entry payload,
// opcode constants and the static-prediction predecoder.
package fetch_pkg;

    localparam int unsigned FETCH_AWIDTH = 32;
    localparam int unsigned FETCH_DWIDTH = 32;

    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_BUBBLE
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
        logic                    pred_taken;
    } fetch_entry_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] offset;
    } predecode_t;

    // JAL is always taken; a B-type branch is taken only when its immediate is negative.
    function automatic predecode_t predecode(logic [31:0] insn);
        predecode_t r;
        r.taken  = 1'b0;
        r.offset = '0;
        if (insn[6:0] == OPC_JAL) begin
            r.taken  = 1'b1;
            r.offset = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        end else if (insn[6:0] == OPC_BRANCH && insn[31]) begin
            r.taken  = 1'b1;
            r.offset = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: imem read port, decode valid/ready port and execute redirect.
interface fetch_queue_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic              valid_o;
    logic              ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
    logic              pred_taken_o;
    logic [CW-1:0]     count_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_rdata_i, ready_i,
        output imem_req_o, imem_addr_o, valid_o, pc_o, insn_o, pred_taken_o, count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_rdata_i, ready_i,
        input  imem_req_o, imem_addr_o, valid_o, pc_o, insn_o, pred_taken_o, count_o
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO with flush; head is read straight from register storage, zero when empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop;

    assign do_pop = pop && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)   wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_q] <= push_data;
    end

    assign head_valid = (cnt_q != '0);
    assign head       = head_valid ? mem[rd_q] : '0;
    assign count      = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// Pipelined fetch unit: one imem read per cycle into a FIFO, flushed on execute redirect.
// Optional backward-branch/JAL static prediction is built when FETCH_STATIC_PRED_EN is defined.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       AWIDTH   = FETCH_AWIDTH,
    parameter int unsigned       DWIDTH   = FETCH_DWIDTH,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int unsigned       DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic              pred_taken;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] fpc_q, inflight_pc_q, pred_target;
    logic              inflight_q, push, pop, issue_ok, pred_redir;
    logic [CW:0]       occ_next;
    entry_t            push_entry, head;
    logic              head_valid;
    logic [CW-1:0]     count;

    assign pop  = head_valid && bus.ready_i;
    assign push = inflight_q && !bus.redirect_i;

    // Occupancy after this edge, counting the read that lands now; gates the next issue.
    assign occ_next = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue_ok = (state_q == S_RUN) && (occ_next < (CW+1)'(DEPTH));

`ifdef FETCH_STATIC_PRED_EN
    predecode_t pd;
    assign pd          = predecode(32'(bus.imem_rdata_i));
    assign pred_redir  = push && pd.taken;
    assign pred_target = inflight_pc_q + AWIDTH'(pd.offset);
`else
    assign pred_redir  = 1'b0;
    assign pred_target = '0;
`endif

    assign push_entry.pc         = inflight_pc_q;
    assign push_entry.insn       = bus.imem_rdata_i;
    assign push_entry.pred_taken = pred_redir;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_BOOT;
        else      state_q <= state_d;
    end

    // FSM next state; execute redirect overrides a prediction bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:   state_d = S_RUN;
            S_RUN:    if (pred_redir) state_d = S_BUBBLE;
            S_BUBBLE: state_d = S_RUN;
            default:  state_d = S_BOOT;
        endcase
        if (bus.redirect_i) state_d = S_RUN;
    end

    // FSM outputs
    always_comb begin
        bus.imem_req_o = 1'b0;
        if (issue_ok) bus.imem_req_o = 1'b1;
    end

    // Fetch PC and in-flight tracking; any redirect cancels the outstanding read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q         <= BASEADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (bus.redirect_i) begin
            fpc_q      <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
        end else if (pred_redir) begin
            fpc_q      <= pred_target;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue_ok;
            if (issue_ok) begin
                inflight_pc_q <= fpc_q;
                fpc_q         <= fpc_q + AWIDTH'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (bus.redirect_i),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.imem_addr_o  = fpc_q;
    assign bus.valid_o      = head_valid;
    assign bus.pc_o         = head.pc;
    assign bus.insn_o       = head.insn;
    assign bus.pred_taken_o = head.pred_taken;
    assign bus.count_o      = count;
endmodule
